// File: rtl/u_icon_arbiter_pkg.sv
// Shared index types for the interconnect channel arbiter, the backend and the execution units.
// Widths here describe the default 4-channel / 4-unit build.
package pkg_dtypes;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_ICON_CHANNELS_DEF = 4;
  localparam int NUM_EXEC_UNITS_DEF    = 4;
  localparam int CH_IDX_W_DEF          = clog2_min1(NUM_ICON_CHANNELS_DEF);
  localparam int EU_IDX_W_DEF          = clog2_min1(NUM_EXEC_UNITS_DEF);

  typedef logic [CH_IDX_W_DEF-1:0] ch_idx_t;
  typedef logic [EU_IDX_W_DEF-1:0] eu_idx_t;

endpackage

// File: rtl/u_icon_arbiter_rr_find_first.sv
// Rotated-priority find-first: returns the first set bit of req at or after ptr, wrapping.
// With ptr tied to zero it degenerates into a plain lowest-index find.
module u_rr_find_first
  import pkg_dtypes::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // upper segment [ptr, WIDTH) first, then wrap to [0, ptr)
    for (int j = 0; j < WIDTH; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/u_icon_arbiter.sv
// Allocates backend interconnect channels to requesting execution units, one channel per unit,
// round-robin over units and lowest-free-index over channels; grants held until released.
module u_icon_arbiter
  import pkg_dtypes::*;
#(
  parameter  int NUM_ICON_CHANNELS = 4,
  parameter  int NUM_EXEC_UNITS    = 4,
  localparam int CH_IDX_W          = clog2_min1(NUM_ICON_CHANNELS),
  localparam int EU_IDX_W          = clog2_min1(NUM_EXEC_UNITS)
) (
  input  logic                                        i_clk,
  input  logic                                        i_rstn,
  input  logic [NUM_EXEC_UNITS-1:0]                   i_req,
  input  logic [NUM_EXEC_UNITS-1:0]                   i_rel,
  output logic [NUM_EXEC_UNITS-1:0]                   o_gnt,
  output logic [NUM_EXEC_UNITS-1:0][CH_IDX_W-1:0]     o_gnt_ch,
  output logic [NUM_ICON_CHANNELS-1:0]                o_ch_busy,
  output logic [NUM_ICON_CHANNELS-1:0][EU_IDX_W-1:0]  o_ch_owner
);

  localparam int NUM_STAGES = (NUM_ICON_CHANNELS < NUM_EXEC_UNITS) ? NUM_ICON_CHANNELS
                                                                   : NUM_EXEC_UNITS;

  logic [EU_IDX_W-1:0]                   rr_ptr;
  logic [EU_IDX_W-1:0]                   rr_nxt;
  logic [NUM_STAGES-1:0]                 stg_vld;
  logic [NUM_STAGES-1:0][EU_IDX_W-1:0]   stg_unit;
  logic [NUM_STAGES-1:0][CH_IDX_W-1:0]   stg_ch;

  // Each stage pairs the next eligible unit (rr order) with the lowest free channel, then
  // removes both from the masks seen by the following stage. Channels freed this cycle are
  // still busy here, so they only become grantable on the next edge.
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    logic [NUM_EXEC_UNITS-1:0]    unit_mask;
    logic [NUM_ICON_CHANNELS-1:0] free_mask;
    logic                         unit_found;
    logic                         ch_found;
    logic [EU_IDX_W-1:0]          unit_idx;
    logic [CH_IDX_W-1:0]          ch_idx;
    logic                         take;

    if (s == 0) begin : g_head
      assign unit_mask = i_req & ~o_gnt;
      assign free_mask = ~o_ch_busy;
    end else begin : g_tail
      assign unit_mask = g_stage[s-1].take
                       ? (g_stage[s-1].unit_mask & ~(NUM_EXEC_UNITS'(1) << g_stage[s-1].unit_idx))
                       : g_stage[s-1].unit_mask;
      assign free_mask = g_stage[s-1].take
                       ? (g_stage[s-1].free_mask & ~(NUM_ICON_CHANNELS'(1) << g_stage[s-1].ch_idx))
                       : g_stage[s-1].free_mask;
    end

    u_rr_find_first #(.WIDTH(NUM_EXEC_UNITS)) u_unit_find (
      .req   (unit_mask),
      .ptr   (rr_ptr),
      .found (unit_found),
      .idx   (unit_idx)
    );

    u_rr_find_first #(.WIDTH(NUM_ICON_CHANNELS)) u_ch_find (
      .req   (free_mask),
      .ptr   ({CH_IDX_W{1'b0}}),
      .found (ch_found),
      .idx   (ch_idx)
    );

    assign take        = unit_found & ch_found;
    assign stg_vld[s]  = take;
    assign stg_unit[s] = unit_idx;
    assign stg_ch[s]   = ch_idx;
  end

  // Stages grant contiguously, so the highest valid stage holds the last granted unit.
  always_comb begin
    rr_nxt = rr_ptr;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (stg_vld[s]) begin
        rr_nxt = (stg_unit[s] == EU_IDX_W'(NUM_EXEC_UNITS - 1)) ? '0
                                                                : stg_unit[s] + EU_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_gnt      <= '0;
      o_gnt_ch   <= '0;
      o_ch_busy  <= '0;
      o_ch_owner <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int u = 0; u < NUM_EXEC_UNITS; u++) begin
        if (i_rel[u] && o_gnt[u]) begin
          o_gnt[u]                 <= 1'b0;
          o_gnt_ch[u]              <= '0;
          o_ch_busy[o_gnt_ch[u]]   <= 1'b0;
          o_ch_owner[o_gnt_ch[u]]  <= '0;
        end
      end
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (stg_vld[s]) begin
          o_gnt[stg_unit[s]]     <= 1'b1;
          o_gnt_ch[stg_unit[s]]  <= stg_ch[s];
          o_ch_busy[stg_ch[s]]   <= 1'b1;
          o_ch_owner[stg_ch[s]]  <= stg_unit[s];
        end
      end
      rr_ptr <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_u_icon_arbiter.sv
// Bench for u_icon_arbiter: a 4-channel and a 2-channel instance, directed scenarios scored
// through an expected-grant queue, then a random run on the 2-channel instance.
module tb_u_icon_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn_a, rstn_b;
  logic [3:0]       req_a, rel_a, req_b, rel_b;

  logic [3:0]       o_gnt_a;
  logic [3:0][1:0]  o_gnt_ch_a;
  logic [3:0]       o_ch_busy_a;
  logic [3:0][1:0]  o_ch_owner_a;

  logic [3:0]       o_gnt_b;
  logic [3:0][0:0]  o_gnt_ch_b;
  logic [1:0]       o_ch_busy_b;
  logic [1:0][1:0]  o_ch_owner_b;

  u_icon_arbiter #(.NUM_ICON_CHANNELS(4), .NUM_EXEC_UNITS(4)) dut_a (
    .i_clk(clk), .i_rstn(rstn_a), .i_req(req_a), .i_rel(rel_a),
    .o_gnt(o_gnt_a), .o_gnt_ch(o_gnt_ch_a), .o_ch_busy(o_ch_busy_a), .o_ch_owner(o_ch_owner_a)
  );

  u_icon_arbiter #(.NUM_ICON_CHANNELS(2), .NUM_EXEC_UNITS(4)) dut_b (
    .i_clk(clk), .i_rstn(rstn_b), .i_req(req_b), .i_rel(rel_b),
    .o_gnt(o_gnt_b), .o_gnt_ch(o_gnt_ch_b), .o_ch_busy(o_ch_busy_b), .o_ch_owner(o_ch_owner_b)
  );

  typedef struct {
    int d;
    int u;
    int ch;
    int cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_on = 1'b0;
  bit          rnd_on = 1'b0;
  logic [3:0]  prev_gnt [2];
  logic [3:0]  req_seen_b;
  int          wait_cnt [4];
  int          rnd_grants = 0;

  logic [3:0][1:0] gch_b_pad;
  logic [3:0]      busy_b_pad;
  logic [3:0][1:0] own_b_pad;

  always_comb begin
    gch_b_pad  = '0;
    own_b_pad  = '0;
    busy_b_pad = {2'b00, o_ch_busy_b};
    for (int u = 0; u < 4; u++) gch_b_pad[u] = {1'b0, o_gnt_ch_b[u]};
    own_b_pad[0] = o_ch_owner_b[0];
    own_b_pad[1] = o_ch_owner_b[1];
  end

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    req_seen_b <= req_b;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int u, input int ch, input int at);
    exp_t e;
    e.d = d; e.u = u; e.ch = ch; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic mon_step(input int d, input logic [3:0] g, input logic [3:0][1:0] gch,
                          input logic [3:0] busy, input logic [3:0][1:0] own, input int nch);
    logic [3:0] newg;
    int         ng;
    bit         ok;
    exp_t       e;
    ok = 1'b1;
    if ($isunknown({g, gch, busy, own})) ok = 1'b0;
    for (int c = 0; c < nch; c++)
      if (busy[c] && !(g[own[c]] && gch[own[c]] == 2'(c))) ok = 1'b0;
    for (int u = 0; u < 4; u++)
      if (g[u] && !(busy[gch[u]] && own[gch[u]] == 2'(u))) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL consistency dut%0d: gnt %b busy %b at cycle %0d", d, g, busy, cyc);
    end

    newg = g & ~prev_gnt[d];
    ng   = $countones(newg);
    for (int u = 0; u < 4; u++) begin
      if (newg[u]) begin
        if (rnd_on && d == 1) begin
          rnd_grants++;
          checks++;
          if (wait_cnt[u] > 3) begin
            errors++;
            $display("FAIL starvation unit %0d: waited %0d grant events, limit 3", u, wait_cnt[u]);
          end
          wait_cnt[u] = 0;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant dut%0d: unit %0d ch %0d at cycle %0d, none expected",
                   d, u, gch[u], cyc);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (e.d != d || e.u != u || e.ch != int'(gch[u]) || e.cyc != cyc) begin
            errors++;
            $display("FAIL grant: got dut%0d unit %0d ch %0d cycle %0d, expected dut%0d unit %0d ch %0d cycle %0d",
                     d, u, gch[u], cyc, e.d, e.u, e.ch, e.cyc);
          end
        end
      end
    end
    if (rnd_on && d == 1)
      for (int u = 0; u < 4; u++)
        if (!newg[u] && req_seen_b[u] && !g[u]) wait_cnt[u] += ng;
    prev_gnt[d] = g;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon_step(0, o_gnt_a, o_gnt_ch_a, o_ch_busy_a, o_ch_owner_a, 4);
      mon_step(1, o_gnt_b, gch_b_pad, busy_b_pad, own_b_pad, 2);
    end
  end

  initial begin
    logic [3:0] req_n, rel_n;
    rstn_a = 1'b0; rstn_b = 1'b0;
    req_a = '0; rel_a = '0; req_b = '0; rel_b = '0;
    prev_gnt[0] = '0; prev_gnt[1] = '0;
    for (int u = 0; u < 4; u++) wait_cnt[u] = 0;

    // reset, with requests asserted to show reset wins
    req_a = 4'b1111; rel_a = 4'b1111;
    repeat (3) tick();
    chk("a_reset_gnt",   o_gnt_a,      32'h0);
    chk("a_reset_gch",   o_gnt_ch_a,   32'h0);
    chk("a_reset_busy",  o_ch_busy_a,  32'h0);
    chk("a_reset_owner", o_ch_owner_a, 32'h0);
    chk("a_reset_rr",    dut_a.rr_ptr, 32'h0);
    chk("b_reset_gnt",   o_gnt_b,      32'h0);
    chk("b_reset_busy",  o_ch_busy_b,  32'h0);
    req_a = '0; rel_a = '0;
    mon_on = 1'b1;

    // 4 channels: all four units granted together, unit u on channel u
    rstn_a = 1'b1;
    tick();
    for (int u = 0; u < 4; u++) push(0, u, u, cyc + 1);
    req_a = 4'b1111;
    tick();
    chk("a_all_gnt",   o_gnt_a,      32'hf);
    chk("a_all_gch",   o_gnt_ch_a,   32'he4);
    chk("a_all_busy",  o_ch_busy_a,  32'hf);
    chk("a_all_owner", o_ch_owner_a, 32'he4);
    chk("a_all_rr",    dut_a.rr_ptr, 32'h0);
    // units 1,3 release while still requesting: release only, regrant one cycle later
    push(0, 1, 1, cyc + 2);
    push(0, 3, 3, cyc + 2);
    rel_a = 4'b1010;
    tick();
    rel_a = '0;
    chk("a_rel_gnt", o_gnt_a, 32'h5);
    tick();
    chk("a_regnt_gnt", o_gnt_a, 32'hf);
    tick();

    // 2 channels: units 0,1 first, 2,3 wait
    rstn_b = 1'b1;
    tick();
    push(1, 0, 0, cyc + 1);
    push(1, 1, 1, cyc + 1);
    req_b = 4'b1111;
    tick();
    req_b = 4'b1100;
    tick();
    chk("b_first_gnt",  o_gnt_b,     32'h3);
    chk("b_first_busy", o_ch_busy_b, 32'h3);
    chk("b_first_rr",   dut_b.rr_ptr, 32'h2);
    push(1, 2, 0, cyc + 2);
    rel_b = 4'b0001;
    tick();
    rel_b = '0;
    chk("b_free_not_regranted", o_ch_busy_b, 32'h2);
    tick();
    req_b = 4'b1000;
    push(1, 3, 1, cyc + 2);
    rel_b = 4'b0010;
    tick();
    rel_b = '0;
    tick();
    req_b = '0;
    tick();
    chk("b_swap_gnt",   o_gnt_b,      32'hc);
    chk("b_swap_owner", o_ch_owner_b, 32'he);

    // stray release from a non-owner, and a one-cycle request while all channels owned
    rel_b = 4'b0001;
    req_b = 4'b0010;
    tick();
    rel_b = '0;
    req_b = '0;
    repeat (3) tick();
    chk("b_stray_gnt",   o_gnt_b,      32'hc);
    chk("b_stray_busy",  o_ch_busy_b,  32'h3);
    chk("b_stray_owner", o_ch_owner_b, 32'he);

    // owner requests and releases in the same cycle
    push(1, 2, 0, cyc + 2);
    req_b = 4'b0100;
    rel_b = 4'b0100;
    tick();
    rel_b = '0;
    chk("b_reqrel_released", o_gnt_b, 32'h8);
    tick();
    req_b = '0;
    chk("b_reqrel_regrant", o_gnt_b, 32'hc);

    // reset while channels are owned and unit 3 requests
    rstn_b = 1'b0;
    req_b  = 4'b1000;
    tick();
    chk("b_midreset_gnt",   o_gnt_b,      32'h0);
    chk("b_midreset_busy",  o_ch_busy_b,  32'h0);
    chk("b_midreset_owner", o_ch_owner_b, 32'h0);
    chk("b_midreset_gch",   o_gnt_ch_b,   32'h0);
    rstn_b = 1'b1;
    push(1, 3, 0, cyc + 1);
    tick();
    req_b = '0;
    chk("b_postreset_gnt", o_gnt_b,      32'h8);
    chk("b_postreset_own", o_ch_owner_b, 32'h3);
    rel_b = 4'b1000;
    tick();
    rel_b = '0;
    tick();
    chk("b_queue_drained", exp_q.size(), 32'h0);

    // random traffic on the 2-channel instance: starvation and ownership watched by the monitor
    rnd_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      for (int u = 0; u < 4; u++) begin
        rel_n[u] = o_gnt_b[u] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        if (o_gnt_b[u])    req_n[u] = 1'b0;
        else if (req_b[u]) req_n[u] = 1'b1;
        else               req_n[u] = ($urandom_range(0, 2) == 0);
      end
      req_b = req_n;
      rel_b = rel_n;
      tick();
    end
    req_b = '0;
    rel_b = '0;
    tick();
    tick();
    rnd_on = 1'b0;
    checks++;
    if (rnd_grants < 100) begin
      errors++;
      $display("FAIL random_activity: got %0d grants, required at least 100", rnd_grants);
    end
    chk("final_queue_empty", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
